// File: rtl/ysyx_22041412_div_ctrl_pkg.sv
// ysyx_22041412_div_ctrl_pkg: shared op encodings, FSM state constants and op decode helpers
//   OP_*      : in_op encodings (DIV, DIVU, REM, REMU)
//   state_t   : controller FSM state type with S_* constants
package ysyx_22041412_div_ctrl_pkg;
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef logic [2:0] state_t;
    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_REQ   = 3'd1;
    localparam state_t S_WAIT  = 3'd2;
    localparam state_t S_DONE  = 3'd3;
    localparam state_t S_DRAIN = 3'd4;

    // bit 0 of the op clear means a signed op, bit 1 set means remainder
    function automatic logic op_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_rem(input logic [1:0] op);
        return op[1];
    endfunction
endpackage

// File: rtl/ysyx_22041412_div_ctrl_if.sv
// ysyx_22041412_div_ctrl_if: request/response bus between the divide controller and the divider
//   div_valid                  : one-cycle request pulse
//   div_dividend, div_divisor  : operands (XLEN)
//   div_word, div_signed       : W flag and signedness
//   div_mode                   : 0 quotient, 1 remainder
//   div_out_valid, div_result  : one-cycle response pulse and result
// modport master = controller side, slave = divider side
interface ysyx_22041412_div_ctrl_if #(parameter int XLEN = 64);
    logic            div_valid;
    logic [XLEN-1:0] div_dividend;
    logic [XLEN-1:0] div_divisor;
    logic            div_word;
    logic            div_signed;
    logic            div_mode;
    logic            div_out_valid;
    logic [XLEN-1:0] div_result;

    modport master (
        output div_valid, div_dividend, div_divisor, div_word, div_signed, div_mode,
        input  div_out_valid, div_result
    );

    modport slave (
        input  div_valid, div_dividend, div_divisor, div_word, div_signed, div_mode,
        output div_out_valid, div_result
    );
endinterface

// File: rtl/ysyx_22041412_div_special.sv
// ysyx_22041412_div_special: detects divide-by-zero and signed overflow and produces the final result
//   op, word    : operation and W flag
//   src1, src2  : operands, already extended from bit 31 for W ops
//   hit         : special case present, result needs no divider
//   result      : final rd value for the special case (W results sign-extended)
module ysyx_22041412_div_special
    import ysyx_22041412_div_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [1:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            hit,
    output logic [XLEN-1:0] result
);
    localparam int H = XLEN / 2;

    logic            zero;
    logic            ovf;
    logic [XLEN-1:0] raw;

    always_comb begin
        zero   = word ? (src2[H-1:0] == '0) : (src2 == '0);
        ovf    = op_signed(op) & (word
               ? (src1[H-1:0] == {1'b1, {(H-1){1'b0}}} && src2[H-1:0] == '1)
               : (src1 == {1'b1, {(XLEN-1){1'b0}}} && src2 == '1));
        hit    = zero | ovf;
        // zero divisor: quotient all ones, remainder = dividend; overflow: quotient = dividend, remainder 0
        raw    = op_rem(op) ? (zero ? src1 : '0) : (zero ? '1 : src1);
        result = word ? {{H{raw[H-1]}}, raw[H-1:0]} : raw;
    end
endmodule

// File: rtl/ysyx_22041412_div_ctrl.sv
// ysyx_22041412_div_ctrl: request-side controller for the multi-cycle divider
//   clk, rst        : clock, synchronous active-low reset
//   in_*            : op from EXU (valid/ready, op, word, src1, src2)
//   flush           : abort current op and drop its result
//   res_*           : result to pipeline (valid/ready, data)
//   div             : divider request/response bus (master side)
module ysyx_22041412_div_ctrl
    import ysyx_22041412_div_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [1:0]                    in_op,
    input  logic                          in_word,
    input  logic [XLEN-1:0]               in_src1,
    input  logic [XLEN-1:0]               in_src2,
    input  logic                          flush,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [XLEN-1:0]               res_data,
    ysyx_22041412_div_ctrl_if.master      div
);
    localparam int H = XLEN / 2;

    state_t          state;
    logic            sgn;
    logic            accept;
    logic [XLEN-1:0] src1_x;
    logic [XLEN-1:0] src2_x;
    logic            sp_hit;
    logic [XLEN-1:0] sp_result;

    always_comb begin
        sgn    = op_signed(in_op);
        src1_x = in_word ? {{H{sgn & in_src1[H-1]}}, in_src1[H-1:0]} : in_src1;
        src2_x = in_word ? {{H{sgn & in_src2[H-1]}}, in_src2[H-1:0]} : in_src2;
        accept = state == S_IDLE && in_valid && !flush;
    end

    assign in_ready      = state == S_IDLE && !flush;
    assign res_valid     = state == S_DONE;
    assign div.div_valid = state == S_REQ;

    ysyx_22041412_div_special #(.XLEN(XLEN)) u_special (
        .op     (in_op),
        .word   (in_word),
        .src1   (src1_x),
        .src2   (src2_x),
        .hit    (sp_hit),
        .result (sp_result)
    );

    // div_* operand/control registers are only rewritten on the next accept,
    // so they stay stable through the capture cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= S_IDLE;
            res_data         <= '0;
            div.div_dividend <= '0;
            div.div_divisor  <= '0;
            div.div_word     <= 1'b0;
            div.div_signed   <= 1'b0;
            div.div_mode     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && sp_hit) begin
                        res_data <= sp_result;
                        state    <= S_DONE;
                    end else if (accept) begin
                        div.div_dividend <= src1_x;
                        div.div_divisor  <= src2_x;
                        div.div_word     <= in_word;
                        div.div_signed   <= sgn;
                        div.div_mode     <= op_rem(in_op);
                        state            <= S_REQ;
                    end
                end
                S_REQ:   state <= flush ? S_DRAIN : S_WAIT;
                S_WAIT: begin
                    // a response arriving with the flush is already consumed, nothing left to drain
                    if (flush)
                        state <= div.div_out_valid ? S_IDLE : S_DRAIN;
                    else if (div.div_out_valid) begin
                        res_data <= div.div_word ? {{H{div.div_result[H-1]}}, div.div_result[H-1:0]} : div.div_result;
                        state    <= S_DONE;
                    end
                end
                S_DONE:  if (flush || res_ready) state <= S_IDLE;
                S_DRAIN: if (div.div_out_valid) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_22041412_div_ctrl.sv
// tb_ysyx_22041412_div_ctrl: bench for the divide controller with a latency-2 divider model and result scoreboard
module tb_ysyx_22041412_div_ctrl;
    import ysyx_22041412_div_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = 2'b00;
    logic        in_word = 1'b0;
    logic [63:0] in_src1 = '0;
    logic [63:0] in_src2 = '0;
    logic        flush = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [63:0] res_data;

    int          n_chk = 0;
    int          n_fail = 0;
    int          n_req = 0;
    logic [63:0] sb[$];
    logic        p1, dov, mode_at_out;

    always #5 clk = ~clk;

    ysyx_22041412_div_ctrl_if #(.XLEN(64)) dbus ();

    ysyx_22041412_div_ctrl #(.XLEN(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_word   (in_word),
        .in_src1   (in_src1),
        .in_src2   (in_src2),
        .flush     (flush),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .div       (dbus)
    );

    // raw divider arithmetic; W results come back zero-extended so the controller must sign-extend
    function automatic logic [63:0] calc(input logic sgn, input logic rem, input logic w,
                                         input logic [63:0] a, input logic [63:0] b);
        logic [31:0] a32, b32, t32;
        logic [63:0] t;
        a32 = a[31:0];
        b32 = b[31:0];
        if (w) begin
            if (b32 == 32'h0) t32 = rem ? a32 : 32'hFFFF_FFFF;
            else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) t32 = rem ? 32'h0 : a32;
            else if (sgn) t32 = rem ? $signed(a32) % $signed(b32) : $signed(a32) / $signed(b32);
            else t32 = rem ? a32 % b32 : a32 / b32;
            return {32'h0, t32};
        end
        if (b == 64'h0) t = rem ? a : '1;
        else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) t = rem ? 64'h0 : a;
        else if (sgn) t = rem ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
        else t = rem ? a % b : a / b;
        return t;
    endfunction

    function automatic logic [63:0] ref_res(input logic [1:0] op, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [63:0] t;
        t = calc(~op[0], op[1], w, a, b);
        return w ? {{32{t[31]}}, t[31:0]} : t;
    endfunction

    // divider model: request at cycle C, response pulse at C+2
    always @(posedge clk) begin
        if (!rst) begin
            p1  <= 1'b0;
            dov <= 1'b0;
        end else begin
            p1  <= dbus.div_valid;
            dov <= p1;
        end
        if (dbus.div_valid) n_req <= n_req + 1;
        if (dov) mode_at_out <= dbus.div_mode;
    end

    assign dbus.div_out_valid = dov;
    assign dbus.div_result = dov ? calc(dbus.div_signed, dbus.div_mode, dbus.div_word, dbus.div_dividend, dbus.div_divisor)
                                 : 64'hDEAD_BEEF_DEAD_BEEF;

    task automatic send(input logic [1:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        in_op = op;
        in_word = w;
        in_src1 = a;
        in_src2 = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // k counts cycles after the accept edge; -1 when res_valid never shows
    task automatic wait_res(input int start, output int k);
        k = start;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            k++;
            if (res_valid) return;
        end
        k = -1;
    endtask

    task automatic take();
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        n_chk++; if (res_data !== 64'h0) begin n_fail++; $display("FAIL reset_res_data: got %h want 0", res_data); end
        n_chk++; if (dbus.div_valid !== 1'b0) begin n_fail++; $display("FAIL reset_div_valid: got %b want 0", dbus.div_valid); end
        n_chk++; if ({dbus.div_dividend, dbus.div_divisor} !== 128'h0) begin n_fail++; $display("FAIL reset_div_operands: got %h %h want 0 0", dbus.div_dividend, dbus.div_divisor); end
        n_chk++; if ({dbus.div_word, dbus.div_signed, dbus.div_mode} !== 3'b000) begin n_fail++; $display("FAIL reset_div_ctrl: got %b want 000", {dbus.div_word, dbus.div_signed, dbus.div_mode}); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_div_rem();
        int k, r0;
        logic [63:0] exp;
        r0 = n_req;
        sb.push_back(64'hFFFF_FFFF_FFFF_FFFA);
        send(OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3);
        @(negedge clk);
        n_chk++; if (dbus.div_valid !== 1'b1) begin n_fail++; $display("FAIL div_req_pulse: got %b want 1", dbus.div_valid); end
        n_chk++; if ({dbus.div_dividend, dbus.div_divisor, dbus.div_word, dbus.div_signed, dbus.div_mode} !== {64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 3'b010})
            begin n_fail++; $display("FAIL div_operands: got %h %h %b want ffffffffffffffec 3 010", dbus.div_dividend, dbus.div_divisor, {dbus.div_word, dbus.div_signed, dbus.div_mode}); end
        wait_res(1, k);
        n_chk++; if (k !== 4) begin n_fail++; $display("FAIL div_latency: got %0d want 4", k); end
        exp = sb.pop_front();
        n_chk++; if (res_data !== exp) begin n_fail++; $display("FAIL div_result: got %h want %h", res_data, exp); end
        n_chk++; if (n_req - r0 !== 1) begin n_fail++; $display("FAIL div_single_req: got %0d want 1", n_req - r0); end
        take();
        sb.push_back(64'hFFFF_FFFF_FFFF_FFFE);
        send(OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3);
        wait_res(0, k);
        exp = sb.pop_front();
        n_chk++; if (res_data !== exp) begin n_fail++; $display("FAIL rem_result: got %h want %h", res_data, exp); end
        n_chk++; if (mode_at_out !== 1'b1) begin n_fail++; $display("FAIL rem_mode_held: got %b want 1", mode_at_out); end
        take();
    endtask

    task automatic test_divu_zero();
        int k, r0;
        logic [63:0] exp;
        r0 = n_req;
        sb.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        send(OP_DIVU, 1'b0, 64'h1234, 64'h0);
        wait_res(0, k);
        n_chk++; if (k !== 1) begin n_fail++; $display("FAIL divu0_latency: got %0d want 1", k); end
        exp = sb.pop_front();
        n_chk++; if (res_data !== exp) begin n_fail++; $display("FAIL divu0_result: got %h want %h", res_data, exp); end
        take();
        @(negedge clk);
        n_chk++; if (n_req !== r0) begin n_fail++; $display("FAIL divu0_no_req: got %0d want %0d", n_req, r0); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL divu0_idle: got %b want 1", in_ready); end
    endtask

    task automatic test_divw_ovf();
        int k, r0;
        logic [63:0] exp;
        r0 = n_req;
        sb.push_back(64'hFFFF_FFFF_8000_0000);
        send(OP_DIV, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_res(0, k);
        n_chk++; if (k !== 1) begin n_fail++; $display("FAIL divw_ovf_latency: got %0d want 1", k); end
        exp = sb.pop_front();
        n_chk++; if (res_data !== exp) begin n_fail++; $display("FAIL divw_ovf_result: got %h want %h", res_data, exp); end
        take();
        sb.push_back(64'h0);
        send(OP_REM, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_res(0, k);
        exp = sb.pop_front();
        n_chk++; if (res_data !== exp) begin n_fail++; $display("FAIL remw_ovf_result: got %h want %h", res_data, exp); end
        n_chk++; if (n_req !== r0) begin n_fail++; $display("FAIL ovf_no_req: got %0d want %0d", n_req, r0); end
        take();
    endtask

    task automatic test_word_ops();
        logic [1:0]  op[3]   = '{OP_REMU, OP_DIVU, OP_DIV};
        logic [63:0] a[3]    = '{64'hFFFF_FFFF_0000_0007, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0000_0000_FFFF_FFEC};
        logic [63:0] b[3]    = '{64'd2, 64'h10, 64'd3};
        logic [63:0] xa[3]   = '{64'h7, 64'h0000_0000_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFEC};
        logic [2:0]  ctl[3]  = '{3'b101, 3'b100, 3'b110};
        logic [63:0] res[3]  = '{64'h1, 64'h0000_0000_0FFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFA};
        int k;
        logic [63:0] exp;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(res[i]);
            send(op[i], 1'b1, a[i], b[i]);
            @(negedge clk);
            n_chk++; if ({dbus.div_word, dbus.div_signed, dbus.div_mode} !== ctl[i])
                begin n_fail++; $display("FAIL wop%0d_ctrl: got %b want %b", i, {dbus.div_word, dbus.div_signed, dbus.div_mode}, ctl[i]); end
            n_chk++; if ({dbus.div_dividend, dbus.div_divisor} !== {xa[i], b[i]})
                begin n_fail++; $display("FAIL wop%0d_operands: got %h %h want %h %h", i, dbus.div_dividend, dbus.div_divisor, xa[i], b[i]); end
            wait_res(1, k);
            n_chk++; if (k !== 4) begin n_fail++; $display("FAIL wop%0d_latency: got %0d want 4", i, k); end
            exp = sb.pop_front();
            n_chk++; if (res_data !== exp) begin n_fail++; $display("FAIL wop%0d_result: got %h want %h", i, res_data, exp); end
            take();
        end
    endtask

    task automatic test_flush();
        int k, r0;
        logic [63:0] exp;
        r0 = n_req;
        send(OP_DIV, 1'b0, 64'd100, 64'd7);
        repeat (2) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        n_chk++; if ({in_ready, res_valid} !== 2'b00) begin n_fail++; $display("FAIL drain_hold: got %b want 00", {in_ready, res_valid}); end
        @(negedge clk);
        n_chk++; if ({in_ready, res_valid} !== 2'b10) begin n_fail++; $display("FAIL drain_exit: got %b want 10", {in_ready, res_valid}); end
        sb.push_back(64'd14);
        send(OP_DIVU, 1'b0, 64'd100, 64'd7);
        wait_res(0, k);
        n_chk++; if (k !== 4) begin n_fail++; $display("FAIL after_drain_latency: got %0d want 4", k); end
        exp = sb.pop_front();
        n_chk++; if (res_data !== exp) begin n_fail++; $display("FAIL after_drain_result: got %h want %h", res_data, exp); end
        n_chk++; if (n_req - r0 !== 2) begin n_fail++; $display("FAIL drain_req_count: got %0d want 2", n_req - r0); end
        take();
        send(OP_DIV, 1'b0, 64'd100, 64'd7);
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        n_chk++; if ({in_ready, res_valid} !== 2'b10) begin n_fail++; $display("FAIL flush_with_resp: got %b want 10", {in_ready, res_valid}); end
        send(OP_DIVU, 1'b0, 64'd5, 64'd0);
        @(negedge clk);
        n_chk++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL done_before_flush: got %b want 1", res_valid); end
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        n_chk++; if ({in_ready, res_valid} !== 2'b10) begin n_fail++; $display("FAIL flush_in_done: got %b want 10", {in_ready, res_valid}); end
        in_op = OP_DIV;
        in_word = 1'b0;
        in_src1 = 64'd9;
        in_src2 = 64'd3;
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1 begin in_valid = 1'b0; flush = 1'b0; end
        @(negedge clk);
        n_chk++; if ({dbus.div_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL idle_flush_ignored: got %b want 01", {dbus.div_valid, in_ready}); end
        n_chk++; if (sb.size() !== 0) begin n_fail++; $display("FAIL flush_scoreboard: got %0d want 0", sb.size()); end
    endtask

    task automatic test_backpressure();
        int k;
        logic [63:0] exp;
        sb.push_back(64'd100);
        send(OP_DIVU, 1'b0, 64'd1000, 64'd10);
        wait_res(0, k);
        exp = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            n_chk++; if ({res_valid, in_ready, res_data} !== {2'b10, exp})
                begin n_fail++; $display("FAIL bp_hold%0d: got %b%b %h want 10 %h", i, res_valid, in_ready, res_data, exp); end
            @(negedge clk);
        end
        take();
        sb.push_back(64'hFFFF_FFFF_FFFF_FFF6);
        send(OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd10);
        @(negedge clk);
        n_chk++; if (dbus.div_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next_accept: got %b want 1", dbus.div_valid); end
        wait_res(1, k);
        exp = sb.pop_front();
        n_chk++; if (res_data !== exp) begin n_fail++; $display("FAIL bp_next_result: got %h want %h", res_data, exp); end
        take();
    endtask

    task automatic test_random();
        int k, sel;
        logic [1:0] op;
        logic w;
        logic [63:0] a, b, exp;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            w = 1'($urandom_range(0, 1));
            a = {$urandom, $urandom};
            sel = $urandom_range(0, 5);
            b = sel == 0 ? 64'h0 : sel == 1 ? '1 : sel == 2 ? {$urandom, $urandom} : 64'($urandom_range(1, 1000));
            if (sel == 1 && $urandom_range(0, 1) == 1) a = w ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
            sb.push_back(ref_res(op, w, a, b));
            send(op, w, a, b);
            wait_res(0, k);
            exp = sb.pop_front();
            n_chk++; if (k < 0 || res_data !== exp)
                begin n_fail++; $display("FAIL rand%0d op=%0d w=%0d a=%h b=%h: got %h (k=%0d) want %h", i, op, w, a, b, res_data, k, exp); end
            take();
        end
    endtask

    task automatic test_reset_mid();
        int k;
        logic [63:0] exp;
        send(OP_DIV, 1'b0, 64'd100, 64'd7);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        n_chk++; if ({in_ready, res_valid, dbus.div_valid} !== 3'b100) begin n_fail++; $display("FAIL mid_reset_state: got %b want 100", {in_ready, res_valid, dbus.div_valid}); end
        n_chk++; if ({res_data, dbus.div_dividend} !== 128'h0) begin n_fail++; $display("FAIL mid_reset_clear: got %h %h want 0 0", res_data, dbus.div_dividend); end
        sb.push_back(64'd14);
        send(OP_DIV, 1'b0, 64'd100, 64'd7);
        wait_res(0, k);
        exp = sb.pop_front();
        n_chk++; if (k !== 4 || res_data !== exp) begin n_fail++; $display("FAIL mid_reset_next: got %h (k=%0d) want %h (k=4)", res_data, k, exp); end
        take();
    endtask

    initial begin
        test_reset();
        test_div_rem();
        test_divu_zero();
        test_divw_ovf();
        test_word_ops();
        test_flush();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule
